// File: rtl/instr_fetch_stage.sv
// RV32I instruction fetch stage: single-outstanding req/gnt/rvalid fetch, registered IF output,
// one-entry skid buffer and branch redirect. Optional FETCH_MISALIGN_CHECK_EN adds a fault state.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  OPcode,
  output logic        misaligned_fault
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StFault} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        kill_q;
  logic        skid_valid_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fault_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      if_valid     <= 1'b0;
      if_pc        <= '0;
      if_instr     <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      // Downstream takes the current word on any unstalled edge; later loads override this.
      if (if_valid && !stall) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end

      if (branch_taken && (state_q != StFault)) begin
        pc_q         <= branch_target;
        if_valid     <= 1'b0;
        if_instr     <= NOP_INSTR;
        skid_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (branch_target[1:0] != 2'b00) begin
          fault_q <= 1'b1;
          kill_q  <= 1'b0;
          state_q <= StFault;
        end else
`endif
        begin
          case (state_q)
            // A request granted this edge is still in flight; its response must be dropped.
            StReq: begin
              if (imem_gnt) begin
                kill_q  <= 1'b1;
                state_q <= StWait;
              end
            end
            StWait: begin
              if (imem_rvalid) begin
                kill_q  <= 1'b0;
                state_q <= StReq;
              end else begin
                kill_q <= 1'b1;
              end
            end
            default: state_q <= StReq;
          endcase
        end
      end else begin
        case (state_q)
          StIdle: state_q <= StReq;
          StReq: begin
            if (imem_gnt) state_q <= StWait;
          end
          StWait: begin
            if (imem_rvalid) begin
              if (kill_q) begin
                kill_q  <= 1'b0;
                state_q <= stall ? StHold : StReq;
              end else if (!stall || !if_valid) begin
                if_valid <= 1'b1;
                if_pc    <= pc_q;
                if_instr <= imem_rdata;
                pc_q     <= pc_q + 32'd4;
                state_q  <= stall ? StHold : StReq;
              end else begin
                skid_valid_q <= 1'b1;
                skid_pc_q    <= pc_q;
                skid_instr_q <= imem_rdata;
                pc_q         <= pc_q + 32'd4;
                state_q      <= StHold;
              end
            end
          end
          StHold: begin
            if (!stall) begin
              if (skid_valid_q) begin
                if_valid     <= 1'b1;
                if_pc        <= skid_pc_q;
                if_instr     <= skid_instr_q;
                skid_valid_q <= 1'b0;
              end
              state_q <= StReq;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_req  = (state_q == StReq);
  assign imem_addr = pc_q;
  assign OPcode    = if_instr[6:0];
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned_fault = fault_q;
`else
  assign misaligned_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: memory model, directed timing checks, then random stall/branch/reset
// traffic with a scoreboard of the expected in-order PC stream.
module tb_instr_fetch_stage;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  OPcode;
  logic        misaligned_fault;

  instr_fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .OPcode          (OPcode),
    .misaligned_fault(misaligned_fault)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          pops = 0;
  bit          started = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;
  // Memory model state: at most one granted request outstanding.
  bit          outstanding = 0;
  logic [31:0] out_addr;
  int          cnt;
  bit          gnt_always = 1;
  int          rv_lo = 0, rv_hi = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, keep the expected stream topped up, run memory.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    if (r) begin
      exp_q.delete();
      next_pc = RST_PC;
    end else if (b) begin
      exp_q.delete();
      next_pc = t;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_pc);
      next_pc += 32'd4;
    end
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom();
    if (r) begin
      outstanding = 0;
    end else if (outstanding) begin
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(out_addr);
        outstanding = 0;
      end else begin
        cnt--;
      end
    end else if (imem_req && (gnt_always || ($urandom_range(1, 0) == 1))) begin
      imem_gnt = 1'b1;
      outstanding = 1;
      out_addr = imem_addr;
      cnt = $urandom_range(rv_hi, rv_lo);
    end
  endtask

  // Monitor: every word taken downstream must be the next PC of the expected stream.
  initial begin
    logic [31:0] p, w;
    forever begin
      @(negedge clk);
      #1;
      if (started && !reset) begin
        if (!if_valid) begin
          chk("bubble_nop", if_instr, NOP);
        end else if (!stall && !branch_taken) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL stream_empty: got pc %h, expected no instruction", if_pc);
          end else begin
            p = exp_q.pop_front();
            w = mem_word(p);
            chk("stream_pc", if_pc, p);
            chk("stream_instr", if_instr, w);
            chk("stream_opcode", 32'(OPcode), 32'(w[6:0]));
            pops++;
          end
        end
      end
    end
  end

  initial begin
    int pops_before;
    logic s, b, r;
    logic [31:0] t;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    started = 1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_opcode", 32'(OPcode), 32'h13);
    chk("rst_fault", 32'(misaligned_fault), 0);

    // Back-to-back fetch with gnt immediately and rvalid one cycle later.
    cycle(0, 0, 0, 0); chk("req_cycle1", 32'(imem_req), 0);
    cycle(0, 0, 0, 0); chk("req_cycle2", 32'(imem_req), 1);
    chk("req_addr", imem_addr, RST_PC);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0); chk("first_valid", 32'(if_valid), 1);
    chk("first_pc", if_pc, RST_PC);
    chk("first_instr", if_instr, mem_word(RST_PC));
    chk("next_addr", imem_addr, 32'h0);
    cycle(0, 0, 0, 0); chk("gap_valid", 32'(if_valid), 0);
    cycle(0, 0, 0, 0); chk("wrap_pc", if_pc, 32'h0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0); chk("pc4", if_pc, 32'h4);
    cycle(0, 0, 0, 0);

    // Stall while the response for 0xC arrives: it must land in the skid buffer.
    cycle(0, 1, 0, 0); chk("stall_pc8", if_pc, 32'h8);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0); chk("hold_pc", if_pc, 32'h8);
    chk("hold_valid", 32'(if_valid), 1);
    chk("hold_req", 32'(imem_req), 0);
    cycle(0, 1, 0, 0); chk("hold_pc2", if_pc, 32'h8);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0); chk("skid_pc", if_pc, 32'hC);
    chk("skid_req", 32'(imem_req), 1);
    cycle(0, 0, 0, 0);
    rv_lo = 2; rv_hi = 2;
    cycle(0, 0, 0, 0); chk("after_skid_pc", if_pc, 32'h10);

    // Redirect while waiting; the stale response must be discarded.
    cycle(0, 0, 1, 32'h100);
    cycle(0, 0, 0, 0); chk("br_valid", 32'(if_valid), 0);
    chk("br_instr", if_instr, NOP);
    chk("br_req_wait", 32'(imem_req), 0);
    cycle(0, 0, 0, 0);
    rv_lo = 0; rv_hi = 0;
    cycle(0, 0, 0, 0); chk("br_req", 32'(imem_req), 1);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_bubble", 32'(if_valid), 0);
    cycle(0, 0, 0, 0);
    rv_lo = 3; rv_hi = 3;
    cycle(0, 0, 0, 0); chk("br_target_pc", if_pc, 32'h100);
    chk("br_target_valid", 32'(if_valid), 1);

    // Reset in the middle of a wait.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0); chk("mid_rst_valid", 32'(if_valid), 0);
    chk("mid_rst_instr", if_instr, NOP);
    chk("mid_rst_req", 32'(imem_req), 0);
    chk("mid_rst_addr", imem_addr, RST_PC);

    // Random traffic: grant jitter, response delays, stalls, redirects, occasional reset.
    gnt_always = 0; rv_lo = 0; rv_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(599, 0) == 0);
      b = !r && ($urandom_range(29, 0) == 0);
      s = ($urandom_range(3, 0) == 0);
      t = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      cycle(r, s, b, t);
    end

    // Unstalled drain: the stream must keep flowing.
    pops_before = pops;
    for (int i = 0; i < 200; i++) cycle(0, 0, 0, 0);
    chk("drain_progress", 32'((pops - pops_before) >= 10), 1);

`ifdef FETCH_MISALIGN_CHECK_EN
    cycle(0, 0, 1, 32'h102);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0);
      chk("fault_set", 32'(misaligned_fault), 1);
      chk("fault_req", 32'(imem_req), 0);
      chk("fault_valid", 32'(if_valid), 0);
    end
`else
    cycle(0, 0, 1, 32'h102);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);
    chk("no_fault", 32'(misaligned_fault), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
